// File: rtl/bist_pkg.sv
// Shared types and helpers for the arithmetic-cell self-test controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TEST    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_t;

    localparam int LFSR_W = 3;
    localparam int MISR_W = 4;
    localparam int CNT_W  = 3;

    localparam logic [MISR_W-1:0] GOLDEN_SIG_DEFAULT = 4'b0110;

    // Maximal-length 3-bit sequence: 001,010,101,011,111,110,100.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[1:0], q[2] ^ q[1]};
    endfunction

    // Signature register: feedback from m[3]^m[2] into bit 0, response bits
    // folded in at positions 0 and 1.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [1:0]        d);
        logic [MISR_W-1:0] n;
        n[0] = m[3] ^ m[2] ^ d[0];
        n[1] = m[0] ^ d[1];
        n[2] = m[1];
        n[3] = m[2];
        return n;
    endfunction

endpackage

// File: rtl/full_adder_cut.sv
// 1-bit full adder used as the circuit under test, with optional sum stuck-at-0.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: a, b, cin - operands; sum, carry - adder result.
module full_adder_cut #(
    parameter bit INJECT_FAULT = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    // The stuck-at fault lets the signature path be shown to catch a defect.
    assign sum   = INJECT_FAULT ? 1'b0 : (a ^ b ^ cin);
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bist_controller.sv
// BIST wrapper: LFSR drives a full-adder CUT, MISR compresses, signature compared to golden.
// Latency: 9 cycles from the first edge with testmode high to a valid fault_detected.
// Backpressure: none; dropping testmode mid-run aborts to IDLE, fault_detected is kept.
// Ports: clock/reset (sync, active-high); w,x,y functional inputs; testmode run/hold;
//        data_out applied CUT vector {a,b,cin}; dataIn CUT response {carry,sum};
//        dataOut MISR signature; fault_detected registered pass/fail flag.
module bist_controller
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 3'b001,
    parameter int                NUM_PATTERNS = 7,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = GOLDEN_SIG_DEFAULT,
    parameter bit                INJECT_FAULT = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w,
    input  logic              x,
    input  logic              y,
    input  logic              testmode,
    output logic [2:0]        data_out,
    output logic [1:0]        dataIn,
    output logic [MISR_W-1:0] dataOut,
    output logic              fault_detected
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    bist_state_t       state;
    logic [LFSR_W-1:0] lfsr;
    logic [MISR_W-1:0] misr;
    logic [CNT_W-1:0]  cnt;

    // LFSR owns the CUT in TEST and COMPARE; otherwise it sees the functional inputs.
    assign data_out = ((state == ST_TEST) || (state == ST_COMPARE)) ? lfsr : {w, x, y};
    assign dataOut  = misr;

    full_adder_cut #(
        .INJECT_FAULT (INJECT_FAULT)
    ) u_cut (
        .a     (data_out[2]),
        .b     (data_out[1]),
        .cin   (data_out[0]),
        .sum   (dataIn[0]),
        .carry (dataIn[1])
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            lfsr           <= LFSR_SEED;
            misr           <= '0;
            cnt            <= '0;
            fault_detected <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lfsr <= LFSR_SEED;
                    misr <= '0;
                    cnt  <= '0;
                    if (testmode) begin
                        state          <= ST_TEST;
                        fault_detected <= 1'b0;
                    end
                end
                ST_TEST: begin
                    if (!testmode) begin
                        // Abort: reseed at once so IDLE starts from a clean slate.
                        state <= ST_IDLE;
                        lfsr  <= LFSR_SEED;
                        misr  <= '0;
                        cnt   <= '0;
                    end else begin
                        misr <= misr_next(misr, dataIn);
                        lfsr <= lfsr_next(lfsr);
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (!testmode) begin
                        state <= ST_IDLE;
                        lfsr  <= LFSR_SEED;
                        misr  <= '0;
                        cnt   <= '0;
                    end else begin
                        fault_detected <= (misr != GOLDEN_SIG);
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Signature and verdict hold until testmode is released.
                    if (!testmode) begin
                        state <= ST_IDLE;
                        lfsr  <= LFSR_SEED;
                        misr  <= '0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       w = 1'b0, x = 1'b0, y = 1'b0;
    logic       testmode = 1'b0;

    logic [2:0] data_out,   data_out_f;
    logic [1:0] dataIn,     dataIn_f;
    logic [3:0] dataOut,    dataOut_f;
    logic       fault_detected, fault_detected_f;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Hand-derived golden run vectors.
    logic [2:0] exp_pat [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
    logic [1:0] exp_din [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01};
    logic [3:0] exp_sig [7] = '{4'b0001, 4'b0011, 4'b0100, 4'b1011, 4'b0100, 4'b1011, 4'b0110};
    // Faulty CUT (sum stuck at 0): responses and signatures.
    logic [1:0] exp_din_f [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [3:0] exp_sig_f [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0110, 4'b1111, 4'b1100, 4'b1000};
    // Full-adder truth table indexed by {w,x,y}: {carry,sum}.
    logic [1:0] fa_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    always #5 clock = ~clock;

    bist_controller dut (
        .clock          (clock),
        .reset          (reset),
        .w              (w),
        .x              (x),
        .y              (y),
        .testmode       (testmode),
        .data_out       (data_out),
        .dataIn         (dataIn),
        .dataOut        (dataOut),
        .fault_detected (fault_detected)
    );

    bist_controller #(.INJECT_FAULT(1'b1)) dut_f (
        .clock          (clock),
        .reset          (reset),
        .w              (w),
        .x              (x),
        .y              (y),
        .testmode       (testmode),
        .data_out       (data_out_f),
        .dataIn         (dataIn_f),
        .dataOut        (dataOut_f),
        .fault_detected (fault_detected_f)
    );

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        w = 1'b1; x = 1'b1; y = 1'b1;
        testmode = 1'b0;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (data_out !== 3'b111) $display("FAIL reset_data_out got %b want 111", data_out);
        else pass_cnt++;
        total_cnt++;
        if (dataIn !== 2'b11) $display("FAIL reset_dataIn got %b want 11", dataIn);
        else pass_cnt++;
        total_cnt++;
        if (dataOut !== 4'b0000) $display("FAIL reset_dataOut got %b want 0000", dataOut);
        else pass_cnt++;
        total_cnt++;
        if (fault_detected !== 1'b0) $display("FAIL reset_fault got %b want 0", fault_detected);
        else pass_cnt++;
    endtask

    task automatic test_golden_run();
        reset = 1'b0;
        testmode = 1'b1;
        tick();  // edge 1: IDLE -> TEST
        for (int k = 0; k < 7; k++) begin
            total_cnt++;
            if (data_out !== exp_pat[k])
                $display("FAIL golden_pat[%0d] got %b want %b", k, data_out, exp_pat[k]);
            else pass_cnt++;
            total_cnt++;
            if (dataIn !== exp_din[k])
                $display("FAIL golden_din[%0d] got %b want %b", k, dataIn, exp_din[k]);
            else pass_cnt++;
            total_cnt++;
            if (dataIn_f !== exp_din_f[k])
                $display("FAIL faulty_din[%0d] got %b want %b", k, dataIn_f, exp_din_f[k]);
            else pass_cnt++;
            tick();  // edges 2..8: captures
            total_cnt++;
            if (dataOut !== exp_sig[k])
                $display("FAIL golden_sig[%0d] got %b want %b", k, dataOut, exp_sig[k]);
            else pass_cnt++;
            total_cnt++;
            if (dataOut_f !== exp_sig_f[k])
                $display("FAIL faulty_sig[%0d] got %b want %b", k, dataOut_f, exp_sig_f[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fault_detected_f !== 1'b0)
            $display("FAIL faulty_flag_before_compare got %b want 0", fault_detected_f);
        else pass_cnt++;
        tick();  // edge 9: verdict
        total_cnt++;
        if (fault_detected !== 1'b0) $display("FAIL golden_flag got %b want 0", fault_detected);
        else pass_cnt++;
        total_cnt++;
        if (fault_detected_f !== 1'b1) $display("FAIL faulty_flag got %b want 1", fault_detected_f);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (fault_detected_f !== 1'b1 || dataOut_f !== 4'b1000)
            $display("FAIL faulty_hold got flag=%b sig=%b want flag=1 sig=1000",
                     fault_detected_f, dataOut_f);
        else pass_cnt++;
        total_cnt++;
        if (fault_detected !== 1'b0 || dataOut !== 4'b0110)
            $display("FAIL golden_hold got flag=%b sig=%b want flag=0 sig=0110",
                     fault_detected, dataOut);
        else pass_cnt++;
    endtask

    task automatic test_normal_mode();
        testmode = 1'b0;
        tick();  // DONE -> IDLE
        total_cnt++;
        if (fault_detected_f !== 1'b1)
            $display("FAIL flag_kept_in_idle got %b want 1", fault_detected_f);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            {w, x, y} = v;
            tick();
            total_cnt++;
            if (data_out !== v || dataIn !== fa_tbl[i] || dataOut !== 4'b0000)
                $display("FAIL normal[%0d] got do=%b di=%b sig=%b want do=%b di=%b sig=0000",
                         i, data_out, dataIn, dataOut, v, fa_tbl[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        w = 1'b1; x = 1'b1; y = 1'b1;
        testmode = 1'b1;
        tick();  // enter TEST
        total_cnt++;
        if (fault_detected_f !== 1'b0)
            $display("FAIL flag_cleared_on_test got %b want 0", fault_detected_f);
        else pass_cnt++;
        tick(); tick(); tick();  // 3 captures
        total_cnt++;
        if (dataOut !== 4'b0100) $display("FAIL abort_pre_sig got %b want 0100", dataOut);
        else pass_cnt++;
        testmode = 1'b0;
        tick();
        total_cnt++;
        if (dataOut !== 4'b0000 || data_out !== 3'b111)
            $display("FAIL abort_idle got sig=%b do=%b want sig=0000 do=111", dataOut, data_out);
        else pass_cnt++;
        testmode = 1'b1;
        tick();
        total_cnt++;
        if (data_out !== 3'b001) $display("FAIL abort_reseed got %b want 001", data_out);
        else pass_cnt++;
        for (int k = 0; k < 7; k++) tick();
        total_cnt++;
        if (dataOut !== 4'b0110) $display("FAIL rerun_sig got %b want 0110", dataOut);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (fault_detected !== 1'b0 || fault_detected_f !== 1'b1)
            $display("FAIL rerun_flags got %b/%b want 0/1", fault_detected, fault_detected_f);
        else pass_cnt++;
        testmode = 1'b0;
        tick();
    endtask

    task automatic test_midrun_reset();
        w = 1'b0; x = 1'b1; y = 1'b0;
        testmode = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();  // now in COMPARE
        total_cnt++;
        if (data_out !== 3'b001 || dataOut !== 4'b0110)
            $display("FAIL compare_state got do=%b sig=%b want do=001 sig=0110", data_out, dataOut);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (data_out !== 3'b010 || dataIn !== 2'b01 || dataOut !== 4'b0000 || fault_detected !== 1'b0)
            $display("FAIL midrun_reset got do=%b di=%b sig=%b flag=%b want 010/01/0000/0",
                     data_out, dataIn, dataOut, fault_detected);
        else pass_cnt++;
        total_cnt++;
        if (dataOut_f !== 4'b0000 || fault_detected_f !== 1'b0)
            $display("FAIL midrun_reset_f got sig=%b flag=%b want 0000/0", dataOut_f, fault_detected_f);
        else pass_cnt++;
        tick();  // reset still high beats testmode
        total_cnt++;
        if (data_out !== 3'b010 || dataOut !== 4'b0000)
            $display("FAIL reset_priority got do=%b sig=%b want 010/0000", data_out, dataOut);
        else pass_cnt++;
        reset = 1'b0;
        testmode = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_golden_run();
        test_normal_mode();
        test_abort();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
